led_mux_scanner: RTL
====================

LED_MUX_SCANNER -- requirements
Module: led_mux_scanner

Interface
REQ-001 SHALL have parameter PRESCALE, default 30, meaning clk30 cycles per PWM tick (1 MHz at 30 MHz).
REQ-002 SHALL have parameter BLANK_TICKS, default 4, meaning all-off ticks before each row is driven.
REQ-003 SHALL have port clk30  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_valid  input  1  brightness write request.
REQ-006 SHALL have port wr_ready  output  1  write accepted when wr_valid && wr_ready.
REQ-007 SHALL have port wr_addr  input  5  LED index = row*7 + column; valid range 0..20.
REQ-008 SHALL have port wr_data  input  8  brightness; 0 = off, 255 = on for 255 of 256 ticks.
REQ-009 SHALL have port commit  input  1  single-cycle request to copy shadow to active at the next frame boundary.
REQ-010 SHALL have port commit_pending  output  1  high from commit until the copy completes.
REQ-011 SHALL have port addr_err  output  1  one-cycle pulse on an accepted write with wr_addr > 20.
REQ-012 SHALL have port frame_sync  output  1  one-cycle pulse at the start of each frame.
REQ-013 SHALL have port led_rgb_multiplex_a  output  7  column drive, active-high.
REQ-014 SHALL have port led_rgb_multiplex_b  output  3  row select, one-hot or zero, active-high.

Function
REQ-015 SHALL hold two 21x8 arrays: shadow (written by port) and active (drives PWM).
REQ-016 SHALL generate a tick every PRESCALE clk30 cycles from a prescaler counter that wraps PRESCALE-1 -> 0.
REQ-017 SHALL run FSM states BLANK and DRIVE, with row index 0..2.
REQ-018 SHALL, in BLANK, drive both outputs to 0 for BLANK_TICKS ticks, then enter DRIVE with pwm_cnt = 0.
REQ-019 SHALL, in DRIVE, set led_rgb_multiplex_b = 1<<row and bit c of led_rgb_multiplex_a = (pwm_cnt < active[row*7+c]), both registered.
REQ-020 SHALL advance pwm_cnt (8-bit) per tick; on the tick at pwm_cnt = 255, enter BLANK with row+1, wrapping 2 -> 0.
REQ-021 SHALL define the frame boundary as the cycle in which row wraps 2 -> 0 into BLANK; frame_sync pulses in that cycle.
REQ-022 SHALL set commit_pending on commit; at the frame boundary with commit_pending = 1, copy all 21 entries shadow -> active in that cycle and clear commit_pending next cycle.
REQ-023 SHALL ignore commit while commit_pending = 1; there is no queueing.
REQ-024 SHALL drive wr_ready = !commit_pending; writes stall while a copy is pending.
REQ-025 SHALL write an accepted entry to shadow on the next edge; wr_addr > 20 is accepted, discarded, and pulses addr_err.
REQ-026 SHALL, for a simultaneous accepted write and commit, write the entry first so that it is included in the copy.
REQ-027 SHALL keep frame timing at exactly 3*(BLANK_TICKS+256) ticks regardless of write or commit activity.
REQ-028 SHALL never drive two rows at once; a row change passes through BLANK.

Reset
REQ-029 SHALL, on rst, set the FSM to BLANK, row 0, with pwm_cnt, prescaler and blank counter at 0.
REQ-030 SHALL, on rst, drive led_rgb_multiplex_a = 0, led_rgb_multiplex_b = 0, commit_pending = 0, addr_err = 0, frame_sync = 0 and wr_ready = 1.
REQ-031 SHALL, on rst, clear the shadow and active arrays to 0.
REQ-032 SHALL treat rst asserted mid-frame or mid-pending as a full reset: the pending commit is dropped, outputs read 0 the cycle after rst, and frame_sync is not emitted for the aborted frame.

Structure
REQ-033 SHALL place constants NUM_ROWS=3, NUM_COLS=7, NUM_LEDS=21 and the FSM state encoding in package led_mux_pkg.
REQ-034 SHALL implement the prescaler as a sub-module tick_gen (parameter PRESCALE; ports clk30, rst, tick).
REQ-035 SHALL register all outputs; no combinational path from inputs to outputs except wr_ready from commit_pending.

Verification
REQ-036 SHALL cover: after reset with PRESCALE=2, BLANK_TICKS=4 -> frame_sync every 3*260*2 = 1560 cycles; outputs stay 0.
REQ-037 SHALL cover: write addr 0 = 128, commit -> after the next frame_sync, a[0] is high 128 ticks and low 128 ticks while b = 3'b001; all other a bits are 0.
REQ-038 SHALL cover: write addr 20 = 255 and addr 7 = 0, commit -> in row 2, a[6] is low only at pwm_cnt 255; in row 1, a[0] is never high.
REQ-039 SHALL cover: commit, then hold wr_valid -> wr_ready stays 0 until the frame boundary, then returns to 1; the held write lands in shadow only, not active.
REQ-040 SHALL cover: write wr_addr 25 -> addr_err pulses for 1 cycle and the shadow array is unchanged.
REQ-041 SHALL cover: assert rst during DRIVE of row 1 with commit_pending=1 -> next cycle a = 0, b = 0, commit_pending = 0, and the active array is all zeros.

Source files
------------

// File: rtl/led_mux_pkg.sv
// led_mux_pkg: shared constants, scan-FSM encoding and LED index helper for
// the 3-row x 7-column multiplexed LED scanner.
// Contents: geometry (NUM_ROWS/NUM_COLS/NUM_LEDS), bus widths, scan_state_e,
// bright_t, led_index(), addr_in_range().
package led_mux_pkg;

  localparam int NUM_ROWS = 3;
  localparam int NUM_COLS = 7;
  localparam int NUM_LEDS = 21;

  localparam int ROW_W  = 2;   // wide enough for row index 0..NUM_ROWS-1
  localparam int ADDR_W = 5;   // wide enough for LED index 0..NUM_LEDS-1
  localparam int DATA_W = 8;   // brightness resolution
  localparam int PWM_W  = 8;   // PWM period of 256 ticks

  typedef enum logic {
    ST_BLANK = 1'b0,           // all outputs off between rows
    ST_DRIVE = 1'b1            // one row selected, columns PWM-modulated
  } scan_state_e;

  typedef logic [DATA_W-1:0] bright_t;

  // Linear LED index as used on the write port: row-major, 7 LEDs per row.
  function automatic int led_index(input int row, input int col);
    return row * NUM_COLS + col;
  endfunction

  // Addresses 21..31 are representable on the port but map to no LED.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (int'(addr) < NUM_LEDS);
  endfunction

endpackage

// File: rtl/led_mux_scanner_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle PWM tick strobe.
// Latency: first tick PRESCALE-1 cycles after reset, then every PRESCALE cycles.
// Backpressure: none; the tick cannot be stalled.
// Ports: clk30 (clock), rst (sync active-high reset), tick (strobe, high
// during the cycle whose closing edge consumes the tick).
module tick_gen #(
  parameter int PRESCALE = 30
) (
  input  logic clk30,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick is asserted on the terminal count so the counter wraps to 0 on the
  // same edge that consumes the tick.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk30) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_mux_scanner.sv
// led_mux_scanner: 3x7 LED matrix scanner with 8-bit PWM per LED, double-buffered
//   brightness (shadow written by the port, active copied on commit at a frame boundary).
// Latency: write lands in shadow on the next edge; commit takes effect at the next frame
//   boundary; all outputs are registered (one cycle behind the scan state).
// Backpressure: wr_ready drops while a commit is pending; frame timing never stalls.
// Ports: clk30/rst clock and sync reset; wr_valid/wr_ready/wr_addr/wr_data brightness
//   write; commit/commit_pending shadow->active copy handshake; addr_err bad-address
//   pulse; frame_sync frame start pulse; led_rgb_multiplex_a columns, _b row select.
module led_mux_scanner
  import led_mux_pkg::*;
#(
  parameter int PRESCALE    = 30,
  parameter int BLANK_TICKS = 4
) (
  input  logic                clk30,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                commit,
  output logic                commit_pending,
  output logic                addr_err,
  output logic                frame_sync,
  output logic [NUM_COLS-1:0] led_rgb_multiplex_a,
  output logic [NUM_ROWS-1:0] led_rgb_multiplex_b
);

  localparam int BLK_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_TICKS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [PWM_W-1:0] PWM_LAST = '1;

  // ------------------------------------------------------------------
  // Tick prescaler
  // ------------------------------------------------------------------
  logic tick;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk30 (clk30),
    .rst   (rst),
    .tick  (tick)
  );

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  scan_state_e         state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [PWM_W-1:0]    pwm_q, pwm_d;
  logic [BLK_W-1:0]    blank_q, blank_d;
  logic                pending_q, pending_d;

  bright_t             shadow_q [NUM_LEDS];
  bright_t             shadow_d [NUM_LEDS];
  bright_t             active_q [NUM_LEDS];
  bright_t             active_d [NUM_LEDS];

  logic [NUM_COLS-1:0] col_q, col_d;
  logic [NUM_ROWS-1:0] row_sel_q, row_sel_d;
  logic                addr_err_q, addr_err_d;
  logic                frame_sync_q, frame_sync_d;

  logic                frame_bnd;   // row wraps last -> 0 on this edge
  logic                wr_fire;     // write handshake completes on this edge

  // ------------------------------------------------------------------
  // Scan FSM: BLANK for BLANK_TICKS ticks, then DRIVE for 256 ticks, per row
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    pwm_d     = pwm_q;
    blank_d   = blank_q;
    frame_bnd = 1'b0;

    if (tick) begin
      case (state_q)
        ST_BLANK: begin
          if (blank_q == BLK_LAST) begin
            state_d = ST_DRIVE;
            blank_d = '0;
            pwm_d   = '0;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (pwm_q == PWM_LAST) begin
            // Every row change goes through BLANK so two rows never overlap.
            state_d = ST_BLANK;
            pwm_d   = '0;
            if (row_q == ROW_LAST) begin
              row_d     = '0;
              frame_bnd = 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            pwm_d = pwm_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_BLANK;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Write port and commit handshake
  // ------------------------------------------------------------------
  assign wr_ready = !pending_q;
  assign wr_fire  = wr_valid && !pending_q;

  always_comb begin
    pending_d = pending_q;
    if (pending_q) begin
      // Further commits are dropped; the flag clears on the copying edge.
      if (frame_bnd) begin
        pending_d = 1'b0;
      end
    end else if (commit) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    addr_err_d = wr_fire && !addr_in_range(wr_addr);
    for (int i = 0; i < NUM_LEDS; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_fire && (wr_addr == ADDR_W'(i))) begin
        shadow_d[i] = wr_data;
      end
    end
  end

  // A write is only accepted while no commit is pending, and the copy only
  // happens while one is, so a write in the commit cycle is always in shadow
  // well before the copy reads it.
  always_comb begin
    for (int i = 0; i < NUM_LEDS; i++) begin
      active_d[i] = active_q[i];
    end
    if (frame_bnd && pending_q) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        active_d[i] = shadow_q[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Output drive: decoded from the current scan state, registered
  // ------------------------------------------------------------------
  always_comb begin
    col_d        = '0;
    row_sel_d    = '0;
    frame_sync_d = frame_bnd;
    if (state_q == ST_DRIVE) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (row_q == ROW_W'(r)) begin
          row_sel_d[r] = 1'b1;
          for (int c = 0; c < NUM_COLS; c++) begin
            col_d[c] = (pwm_q < active_q[led_index(r, c)]);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk30) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      row_q        <= '0;
      pwm_q        <= '0;
      blank_q      <= '0;
      pending_q    <= 1'b0;
      col_q        <= '0;
      row_sel_q    <= '0;
      addr_err_q   <= 1'b0;
      frame_sync_q <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      pwm_q        <= pwm_d;
      blank_q      <= blank_d;
      pending_q    <= pending_d;
      col_q        <= col_d;
      row_sel_q    <= row_sel_d;
      addr_err_q   <= addr_err_d;
      frame_sync_q <= frame_sync_d;
      for (int i = 0; i < NUM_LEDS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign commit_pending      = pending_q;
  assign addr_err            = addr_err_q;
  assign frame_sync          = frame_sync_q;
  assign led_rgb_multiplex_a = col_q;
  assign led_rgb_multiplex_b = row_sel_q;

endmodule
